// File: rtl/speed_select_ctrl.sv
// Speed-level selector driven by two debounced pushbuttons.
// Right steps the level up, left steps it down, both wrap mod 4.

module speed_select_dbnc #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic raw,
  output logic press
);

  localparam logic [23:0] LAST = 24'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    HELD,
    WAIT_RELEASE
  } state_t;

  state_t      state;
  logic        meta;
  logic        sync;
  logic [23:0] cnt;

  // run low keeps everything parked until the reset synchronizer releases
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
    end else if (!run) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      unique case (state)
        IDLE: begin
          if (sync) begin
            state <= WAIT_PRESS;
            cnt   <= '0;
          end
        end
        WAIT_PRESS: begin
          if (!sync) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
            state <= HELD;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        HELD: begin
          if (!sync) begin
            state <= WAIT_RELEASE;
            cnt   <= '0;
          end
        end
        WAIT_RELEASE: begin
          if (sync) begin
            state <= HELD;
          end else if (cnt == LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign press = run && (state == WAIT_PRESS) && sync && (cnt == LAST);

endmodule

module speed_select_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned SPEED0 = 100_000_000,
  parameter int unsigned SPEED1 = 50_000_000,
  parameter int unsigned SPEED2 = 25_000_000,
  parameter int unsigned SPEED3 = 12_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_r,
  input  logic        btn_l,
  output logic [27:0] speed_sel,
  output logic [1:0]  level,
  output logic        speed_update
);

  localparam logic [27:0] S0 = 28'(SPEED0);
  localparam logic [27:0] S1 = 28'(SPEED1);
  localparam logic [27:0] S2 = 28'(SPEED2);
  localparam logic [27:0] S3 = 28'(SPEED3);

  logic [1:0] rsync;
  logic       run;
  logic       inc;
  logic       dec;
  logic [1:0] next;
  logic       step;

  function automatic logic [27:0] speed_of(input logic [1:0] l);
    logic [27:0] s;
    s = S0;
    unique case (l)
      2'd0: s = S0;
      2'd1: s = S1;
      2'd2: s = S2;
      2'd3: s = S3;
      default: s = S0;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsync <= 2'b00;
    end else begin
      rsync <= {rsync[0], 1'b1};
    end
  end

  assign run = rsync[1];

  speed_select_dbnc #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dbnc_r (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .raw  (btn_r),
    .press(inc)
  );

  speed_select_dbnc #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dbnc_l (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .raw  (btn_l),
    .press(dec)
  );

  // simultaneous presses cancel out
  always_comb begin
    next = level;
    step = 1'b0;
    unique case (1'b1)
      (inc && !dec): begin
        next = level + 2'd1;
        step = 1'b1;
      end
      (dec && !inc): begin
        next = level - 2'd1;
        step = 1'b1;
      end
      default: begin
        next = level;
        step = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level        <= 2'd0;
      speed_sel    <= S0;
      speed_update <= 1'b0;
    end else if (!run) begin
      level        <= 2'd0;
      speed_sel    <= S0;
      speed_update <= 1'b0;
    end else begin
      level        <= next;
      speed_sel    <= speed_of(next);
      speed_update <= step;
    end
  end

endmodule

// File: tb/tb_speed_select_ctrl.sv
// Directed bench for speed_select_ctrl with DEBOUNCE_CYCLES=4.
// Vector table for press patterns plus hand sequences for reset cases.

`timescale 1ns/1ps

module tb_speed_select_ctrl;

  logic        clk;
  logic        rst;
  logic        btn_r;
  logic        btn_l;
  logic [27:0] speed_sel;
  logic [1:0]  level;
  logic        speed_update;

  int errors;
  int checks;
  int pulses;
  int inv_err;

  typedef struct {
    logic        r;
    logic        l;
    int          hold;
    logic [1:0]  lvl;
    logic [27:0] spd;
    int          npulse;
  } vec_t;

  vec_t vt[10];

  speed_select_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SPEED0(100_000_000),
    .SPEED1(50_000_000),
    .SPEED2(25_000_000),
    .SPEED3(12_500_000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_r       (btn_r),
    .btn_l       (btn_l),
    .speed_sel   (speed_sel),
    .level       (level),
    .speed_update(speed_update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] exp_speed(input logic [1:0] l);
    logic [27:0] s;
    case (l)
      2'd0: s = 28'd100_000_000;
      2'd1: s = 28'd50_000_000;
      2'd2: s = 28'd25_000_000;
      default: s = 28'd12_500_000;
    endcase
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // advance one clock, sample at the falling edge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    if (speed_update === 1'b1) pulses++;
    if (speed_sel !== exp_speed(level)) inv_err++;
  endtask

  initial begin
    int first;

    errors  = 0;
    checks  = 0;
    pulses  = 0;
    inv_err = 0;
    rst     = 1'b0;
    btn_r   = 1'b0;
    btn_l   = 1'b0;

    vt[0] = '{1'b1, 1'b0, 10, 2'd2, 28'd25_000_000, 1};
    vt[1] = '{1'b1, 1'b0, 10, 2'd3, 28'd12_500_000, 1};
    vt[2] = '{1'b1, 1'b0, 10, 2'd0, 28'd100_000_000, 1};
    vt[3] = '{1'b0, 1'b1, 2, 2'd0, 28'd100_000_000, 0};
    vt[4] = '{1'b0, 1'b1, 10, 2'd3, 28'd12_500_000, 1};
    vt[5] = '{1'b1, 1'b1, 10, 2'd3, 28'd12_500_000, 0};
    vt[6] = '{1'b0, 1'b1, 10, 2'd2, 28'd25_000_000, 1};
    vt[7] = '{1'b1, 1'b0, 4, 2'd2, 28'd25_000_000, 0};
    vt[8] = '{1'b1, 1'b0, 5, 2'd3, 28'd12_500_000, 1};
    vt[9] = '{1'b0, 1'b1, 10, 2'd2, 28'd25_000_000, 1};

    repeat (3) @(negedge clk);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_speed", 32'(speed_sel), 32'd100_000_000);
    rst = 1'b1;
    repeat (20) cyc();
    chk("idle_level", 32'(level), 32'd0);
    chk("idle_speed", 32'(speed_sel), 32'd100_000_000);
    chk("idle_pulses", 32'(pulses), 32'd0);

    pulses = 0;
    first  = 0;
    btn_r  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (speed_update === 1'b1 && first == 0) first = k;
    end
    btn_r = 1'b0;
    repeat (12) cyc();
    chk("latency", 32'(first), 32'd7);
    chk("first_level", 32'(level), 32'd1);
    chk("first_speed", 32'(speed_sel), 32'd50_000_000);
    chk("first_pulses", 32'(pulses), 32'd1);

    for (int i = 0; i < 10; i++) begin
      pulses = 0;
      btn_r  = vt[i].r;
      btn_l  = vt[i].l;
      repeat (vt[i].hold) cyc();
      btn_r = 1'b0;
      btn_l = 1'b0;
      repeat (12) cyc();
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vt[i].lvl));
      chk($sformatf("vec%0d_speed", i), 32'(speed_sel), 32'(vt[i].spd));
      chk($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(vt[i].npulse));
    end

    // release bounce must not produce a second step
    pulses = 0;
    btn_r  = 1'b1;
    repeat (10) cyc();
    btn_r = 1'b0;
    repeat (2) cyc();
    btn_r = 1'b1;
    repeat (6) cyc();
    btn_r = 1'b0;
    repeat (12) cyc();
    chk("bounce_level", 32'(level), 32'd3);
    chk("bounce_pulses", 32'(pulses), 32'd1);

    btn_l = 1'b1;
    repeat (10) cyc();
    btn_l = 1'b0;
    repeat (12) cyc();
    chk("pre_rst_level", 32'(level), 32'd2);

    // asynchronous reset in the middle of a debounce
    btn_r = 1'b1;
    repeat (4) cyc();
    #2 rst = 1'b0;
    #1;
    chk("async_level", 32'(level), 32'd0);
    chk("async_speed", 32'(speed_sel), 32'd100_000_000);
    chk("async_update", 32'(speed_update), 32'd0);
    btn_r = 1'b0;
    repeat (3) cyc();
    rst    = 1'b1;
    pulses = 0;
    repeat (20) cyc();
    chk("post_rst_pulses", 32'(pulses), 32'd0);
    chk("post_rst_level", 32'(level), 32'd0);

    // button held across reset release counts as one fresh press
    btn_r = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    rst    = 1'b1;
    pulses = 0;
    repeat (20) cyc();
    btn_r = 1'b0;
    repeat (12) cyc();
    chk("held_rst_pulses", 32'(pulses), 32'd1);
    chk("held_rst_level", 32'(level), 32'd1);
    chk("held_rst_speed", 32'(speed_sel), 32'd50_000_000);

    chk("spd_tracks_level", 32'(inv_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/speed_select_ctrl.md
SPEED_SELECT_CTRL -- requirements
Module: speed_select_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 2_000_000, consecutive stable synchronized-input cycles required to accept a press or a release (20 ms at 100 MHz); legal range 2 to 2^24-1.
REQ-002 Parameter: SPEED0, 100_000_000, speed_sel value for level 0.
REQ-003 Parameter: SPEED1, 50_000_000, speed_sel value for level 1.
REQ-004 Parameter: SPEED2, 25_000_000, speed_sel value for level 2.
REQ-005 Parameter: SPEED3, 12_500_000, speed_sel value for level 3; all SPEEDn SHALL fit in 28 bits.
REQ-006 Port: clk  input  1  single system clock, all logic on its rising edge.
REQ-007 Port: rst  input  1  asynchronous, active-low reset.
REQ-008 Port: btn_r  input  1  raw asynchronous right pushbutton, active-high, increments the speed level.
REQ-009 Port: btn_l  input  1  raw asynchronous left pushbutton, active-high, decrements the speed level.
REQ-010 Port: speed_sel  output  28  blink period count for the LED controller, registered.
REQ-011 Port: level  output  2  current speed level index 0-3, registered.
REQ-012 Port: speed_update  output  1  single-cycle pulse, high in the cycle in which a new speed_sel value is first presented.

Function
REQ-013 Each button SHALL pass through its own 2-flop synchronizer before any other logic uses it.
REQ-014 Each button SHALL have an independent debounce FSM with states IDLE, WAIT_PRESS, HELD and WAIT_RELEASE.
REQ-015 IDLE: synchronized input high -> WAIT_PRESS, counter cleared; input low -> stay in IDLE.
REQ-016 WAIT_PRESS: counter increments each cycle the input is high; any low sample -> IDLE; counter reaching DEBOUNCE_CYCLES-1 while input high -> HELD, with a one-cycle accepted-press strobe.
REQ-017 HELD: input low -> WAIT_RELEASE, counter cleared; input high -> stay in HELD; no further strobes while in HELD (no auto-repeat).
REQ-018 WAIT_RELEASE: counter increments each cycle the input is low; any high sample -> HELD; counter reaching DEBOUNCE_CYCLES-1 while input low -> IDLE.
REQ-019 Debounce counters SHALL be 24 bits and SHALL never wrap.
REQ-020 An accepted btn_r strobe alone SHALL set level to (level+1) mod 4, so 3 wraps to 0.
REQ-021 An accepted btn_l strobe alone SHALL set level to (level-1) mod 4, so 0 wraps to 3.
REQ-022 Accepted btn_r and btn_l strobes in the same cycle SHALL cancel: level unchanged, no speed_update pulse.
REQ-023 speed_sel SHALL equal SPEED[level] at all times after reset, updated on the same clock edge as level.
REQ-024 speed_update SHALL be high for exactly the one cycle following the edge on which level changes; otherwise it SHALL be low.
REQ-025 Latency: a clean press SHALL change level 2 (synchronizer) + DEBOUNCE_CYCLES + 1 cycles after the raw input first rises.
REQ-026 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL cause no level change.

Reset
REQ-027 rst low SHALL immediately and asynchronously force: level=0, speed_sel=SPEED0, speed_update=0, both FSMs in IDLE, counters 0, synchronizer flops 0.
REQ-028 Release of rst SHALL be taken synchronously through a 2-flop reset synchronizer, and no state change SHALL occur before the first clk edge after that synchronizer deasserts.
REQ-029 A button held through reset release SHALL be debounced from IDLE as a new press, giving exactly one level increment or decrement.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Reset then idle 20 cycles -> level=0, speed_sel=100_000_000, speed_update never high.
REQ-031 btn_r high for 10 cycles -> level=1, speed_sel=50_000_000, exactly one speed_update pulse, 7 cycles after btn_r rises.
REQ-032 Four clean btn_r presses separated by 10 low cycles -> levels 1,2,3,0 in that order; final speed_sel=100_000_000.
REQ-033 btn_l pulse of 2 cycles, then btn_l held for 10 cycles from level 0 -> glitch ignored, then level=3, speed_sel=12_500_000.
REQ-034 btn_r and btn_l rising on the same cycle and held for 10 cycles -> level unchanged, no speed_update pulse.
REQ-035 rst asserted mid-debounce while at level 2 -> level=0 and speed_sel=100_000_000 in the same cycle, with no pulse after release unless the button remains held.
